// File: rtl/key_repeat_if.sv
// Key-repeat signal bundle: debounced key level in, action strobe and press status out.
interface key_repeat_if;
    logic       key_level;
    logic       key_pulse;
    logic       key_held;
    logic [7:0] press_cnt;

    modport master (output key_level, input key_pulse, key_held, press_cnt);
    modport slave  (input key_level, output key_pulse, key_held, press_cnt);
endinterface

// File: rtl/key_repeat.sv
// Press/auto-repeat strobe generator for one game button (IDLE -> DELAY -> REPEAT).
// Optional KEY_REPEAT_ACCEL_EN halves the repeat interval once 9 pulses were emitted in a press.
module key_repeat #(
    parameter int CLK_FREQ  = 50000000,
    parameter int DELAY_MS  = 300,
    parameter int REPEAT_MS = 80
) (
    input logic         clk,
    input logic         rst,
    key_repeat_if.slave bus
);
    localparam int DELAY_CYC  = CLK_FREQ / 1000 * DELAY_MS;
    localparam int REPEAT_CYC = CLK_FREQ / 1000 * REPEAT_MS;
    localparam int MAX_CYC    = (DELAY_CYC > REPEAT_CYC) ? DELAY_CYC : REPEAT_CYC;
    localparam int CNT_W      = $clog2(MAX_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pulse, pulse_nxt;
    logic             held, held_nxt;
    logic [7:0]       pcnt, pcnt_nxt;
    logic [7:0]       pcnt_inc;
    logic [CNT_W-1:0] rep_term;

    assign pcnt_inc = (pcnt == 8'hFF) ? pcnt : pcnt + 8'd1;

`ifdef KEY_REPEAT_ACCEL_EN
    localparam int FAST_CYC = (REPEAT_CYC / 2 < 2) ? 2 : REPEAT_CYC / 2;
    // press_cnt is registered, so the faster interval starts right after the 9th pulse
    assign rep_term = (pcnt >= 8'd9) ? CNT_W'(FAST_CYC - 1) : CNT_W'(REPEAT_CYC - 1);
`else
    assign rep_term = CNT_W'(REPEAT_CYC - 1);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        pcnt_nxt  = pcnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.key_level) begin
                    state_nxt = DELAY;
                    pulse_nxt = 1'b1;
                    pcnt_nxt  = 8'd1;
                end
            end
            DELAY: begin
                // release is checked first so it beats a coincident terminal count
                if (!bus.key_level) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DELAY_CYC - 1)) begin
                    state_nxt = REPEAT;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                    pcnt_nxt  = pcnt_inc;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!bus.key_level) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == rep_term) begin
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                    pcnt_nxt  = pcnt_inc;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        held_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            held  <= 1'b0;
            pcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
            held  <= held_nxt;
            pcnt  <= pcnt_nxt;
        end
    end

    assign bus.key_pulse = pulse;
    assign bus.key_held  = held;
    assign bus.press_cnt = pcnt;
endmodule

// File: tb/tb_key_repeat.sv
// Scoreboard bench for key_repeat: a press-age model predicts every cycle's outputs.
module tb_key_repeat;
    localparam int CLK_FREQ  = 1000;
    localparam int DELAY_MS  = 10;
    localparam int REPEAT_MS = 4;
    localparam int DLY = CLK_FREQ / 1000 * DELAY_MS;
    localparam int REP = CLK_FREQ / 1000 * REPEAT_MS;

    typedef struct {
        logic       pulse;
        logic       held;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    key_repeat_if bus();

    key_repeat #(.CLK_FREQ(CLK_FREQ), .DELAY_MS(DELAY_MS), .REPEAT_MS(REPEAT_MS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state: a press is described by its age in sampled-high edges and the age of the next pulse.
    bit   m_active = 0;
    int   m_age = 0;
    int   m_next = 0;
    int   m_cnt = 0;
    logic m_pulse = 0;
    logic m_held = 0;

    function automatic int next_gap(input int pulses);
        int g;
        g = REP;
`ifdef KEY_REPEAT_ACCEL_EN
        if (pulses >= 9) g = (REP / 2 < 2) ? 2 : REP / 2;
`endif
        return g;
    endfunction

    task automatic model_step();
        exp_t e;
        m_pulse = 0;
        if (rst) begin
            m_active = 0;
            m_cnt = 0;
            m_held = 0;
        end else if (!bus.key_level) begin
            m_active = 0;
            m_held = 0;
        end else begin
            m_held = 1;
            if (!m_active) begin
                m_active = 1;
                m_age = 0;
                m_next = DLY;
                m_cnt = 1;
                m_pulse = 1;
            end else begin
                m_age++;
                if (m_age == m_next) begin
                    m_pulse = 1;
                    if (m_cnt < 255) m_cnt++;
                    m_next = m_age + next_gap(m_cnt);
                end
            end
        end
        e.pulse = m_pulse;
        e.held = m_held;
        e.cnt = 8'(m_cnt);
        q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL queue cycle %0d: no expected entry, got pulse=%0b held=%0b cnt=%0d",
                     cyc, bus.key_pulse, bus.key_held, bus.press_cnt);
        end else begin
            e = q.pop_front();
            if (bus.key_pulse !== e.pulse || bus.key_held !== e.held || bus.press_cnt !== e.cnt) begin
                failures++;
                $display("FAIL outputs cycle %0d: got pulse=%0b held=%0b cnt=%0d, expected pulse=%0b held=%0b cnt=%0d",
                         cyc, bus.key_pulse, bus.key_held, bus.press_cnt, e.pulse, e.held, e.cnt);
            end
        end
    end

    task automatic step(input logic r, input logic k, input int n);
        rst = r;
        bus.key_level = k;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.key_level = 1'b1;
        step(1, 1, 3);      // reset with key high, then press on release
        step(0, 1, 5);
        step(0, 0, 6);
        step(0, 1, 5);      // short press
        step(0, 0, 4);
        step(0, 1, 30);     // long hold
        step(0, 0, 5);
        step(0, 1, 10);     // release on DELAY terminal edge
        step(0, 0, 5);
        step(0, 1, 17);     // reset in REPEAT, key still high
        step(1, 1, 1);
        step(0, 1, 6);
        step(0, 0, 3);
        step(0, 1, 60);     // accel window
        step(0, 0, 3);
        step(0, 1, 1100);   // press_cnt saturation
        step(0, 0, 4);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(15, 0) == 0)
                step(1, 1'($urandom_range(1, 0)), $urandom_range(3, 1));
            step(0, 1, $urandom_range(40, 1));
            step(0, 0, $urandom_range(8, 1));
        end
        step(0, 0, 3);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() > 1) begin
            failures++;
            $display("FAIL drain: %0d entries left, required at most 1", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
